// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths,
// requester identifiers and the lock FSM state encoding.
package dmem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Requester identifiers; also the round-robin pointer and read-owner tag values
    localparam logic REQ_C = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DLOCK = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Bit 0 of req/gnt is the core (C),
// bit 1 is the debug port (D). Pointer names the port that wins a tie
// and flips to the loser after every grant; force_c_i parks it on C.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       force_c_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant: a lone requester wins, a tie goes to the pointer's port
    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = req_i[0] & (~req_i[1] | (ptr_q == REQ_C));
        gnt_o[1] = req_i[1] & (~req_i[0] | (ptr_q == REQ_D));
    end

    // Pointer update: force to C has priority, otherwise favour the port that just lost
    always_comb begin
        ptr_d = ptr_q;
        if (force_c_i) begin
            ptr_d = REQ_C;
        end else if (gnt_o[0]) begin
            ptr_d = REQ_D;
        end else if (gnt_o[1]) begin
            ptr_d = REQ_C;
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ_C;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store path (C) and the
// debug/program-loader port (D). Registers one winning command per
// cycle onto the memory bus, steers read data back via an owner-tag
// shift register, supports an exclusive debug lock with read drain,
// and produces the core stall.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state_q;
    arb_state_e state_d;

    // Read tag pipeline: stage k is visible k+1 cycles after the grant,
    // so the last stage lines up with mem_rdata.
    logic [RD_LAT:0] vld_q;
    logic [RD_LAT:0] own_q;

    logic              c_pend_q;
    logic              c_pend_d;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic       c_arb_en;
    logic       d_arb_en;
    logic       core_ok;
    logic       in_flight;
    logic       force_c;
    logic       any_gnt;
    logic       rd_gnt;
    logic [1:0] arb_req;
    logic [1:0] arb_gnt;

    // A read whose data lands this cycle is complete; only earlier stages count as in flight
    assign in_flight = |vld_q[RD_LAT-1:0];

    // The core may issue a new access once its outstanding read returns
    assign core_ok = ~c_pend_q | c_rvalid;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: lock request drains outstanding reads before granting exclusivity
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB: begin
                if (d_lock) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!d_lock)        state_d = ST_ARB;
                else if (!in_flight) state_d = ST_DLOCK;
            end
            ST_DLOCK: begin
                if (!d_lock) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
    end

    // FSM outputs: which ports may compete this cycle, and pointer reset on lock exit
    always_comb begin
        c_arb_en = reset & (state_q == ST_ARB);
        d_arb_en = reset & ((state_q == ST_ARB) | (state_q == ST_DLOCK));
        force_c  = (state_q == ST_DLOCK) & ~d_lock;
    end

    assign arb_req = {d_req & d_arb_en, c_req & c_arb_en & core_ok};

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (reset),
        .req_i     (arb_req),
        .force_c_i (force_c),
        .gnt_o     (arb_gnt)
    );

    assign c_gnt   = arb_gnt[0];
    assign d_gnt   = arb_gnt[1];
    assign any_gnt = c_gnt | d_gnt;
    assign rd_gnt  = (c_gnt & ~c_we) | (d_gnt & ~d_we);

    // Command register: capture the winner's command, strobe only after a grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= any_gnt;
            if (any_gnt) begin
                mem_we_q    <= d_gnt ? d_we    : c_we;
                mem_addr_q  <= d_gnt ? d_addr  : c_addr;
                mem_wdata_q <= d_gnt ? d_wdata : c_wdata;
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Tag pipeline entry: valid for reads only, owner is the granted port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q[0] <= 1'b0;
            own_q[0] <= REQ_C;
        end else begin
            vld_q[0] <= rd_gnt;
            own_q[0] <= d_gnt ? REQ_D : REQ_C;
        end
    end

    generate
        for (genvar gi = 1; gi <= RD_LAT; gi++) begin : g_tag
            // Tag pipeline shift stage
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_q[gi] <= 1'b0;
                    own_q[gi] <= REQ_C;
                end else begin
                    vld_q[gi] <= vld_q[gi-1];
                    own_q[gi] <= own_q[gi-1];
                end
            end
        end
    endgenerate

    assign c_rvalid = vld_q[RD_LAT] & (own_q[RD_LAT] == REQ_C);
    assign d_rvalid = vld_q[RD_LAT] & (own_q[RD_LAT] == REQ_D);

    // Read data holding registers keep the last returned word between responses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (c_rvalid) c_rdata_q <= mem_rdata;
            if (d_rvalid) d_rdata_q <= mem_rdata;
        end
    end

    assign c_rdata = c_rvalid ? mem_rdata : c_rdata_q;
    assign d_rdata = d_rvalid ? mem_rdata : d_rdata_q;

    // Core read outstanding flag: set on a core read grant, cleared when its data returns
    always_comb begin
        c_pend_d = c_pend_q & ~c_rvalid;
        if (c_gnt & ~c_we) c_pend_d = 1'b1;
    end

    // Core pending register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_pend_q <= 1'b0;
        end else begin
            c_pend_q <= c_pend_d;
        end
    end

    // Stall covers an unserved request and a read that has not yet returned,
    // including one granted this very cycle
    assign c_stall = reset & ((c_req & ~c_gnt) | (c_gnt & ~c_we) | (c_pend_q & ~c_rvalid));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with RD_LAT=1 and a synchronous
// one-cycle memory model. Inputs change on the falling edge; all
// outputs are sampled 1 ns later.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        c_req = 1'b0;
    logic        c_we = 1'b0;
    logic [15:0] c_addr = '0;
    logic [15:0] c_wdata = '0;
    logic        c_gnt;
    logic        c_rvalid;
    logic [15:0] c_rdata;
    logic        c_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_lock = 1'b0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;

    logic [15:0] mem_model [0:1023];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W (16),
        .DATA_W (16),
        .RD_LAT (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .c_stall   (c_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_lock    (d_lock),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous memory: data for a read command appears one cycle later
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr[9:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge, then settle
    task automatic set_in(input logic r,
                          input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                          input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
                          input logic dl);
        @(negedge clk);
        cyc++;
        reset = r;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        d_lock = dl;
        #1;
        $display("cyc %0d: rst_n=%0b C(req=%0b we=%0b a=%h) D(req=%0b we=%0b a=%h lock=%0b) -> cg=%0b dg=%0b en=%0b a=%h crv=%0b drv=%0b stall=%0b",
                 cyc, r, cr, cw, ca, dr, dw, da, dl, c_gnt, d_gnt, mem_en, mem_addr, c_rvalid, d_rvalid, c_stall);
    endtask

    task automatic idle();
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 16'h0000;
        mem_model[10'h010] = 16'hBEEF;
        mem_model[10'h020] = 16'h1111;
        mem_model[10'h030] = 16'h2222;

        // Reset held with both ports requesting
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
            check_eq("rst_c_gnt", c_gnt, 0);
            check_eq("rst_d_gnt", d_gnt, 0);
            check_eq("rst_mem_en", mem_en, 0);
            check_eq("rst_stall", c_stall, 0);
        end
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_c_rvalid", c_rvalid, 0);
        check_eq("rst_d_rvalid", d_rvalid, 0);
        check_eq("rst_c_rdata", c_rdata, 0);
        check_eq("rst_d_rdata", d_rdata, 0);
        idle();
        check_eq("post_rst_en", mem_en, 0);

        // Contention: both write continuously, grants alternate starting with C
        set_in(1'b1, 1'b1, 1'b1, 16'h0002, 16'hC0C0, 1'b1, 1'b1, 16'h0100, 16'hD0D0, 1'b0);
        check_eq("ct0_c_gnt", c_gnt, 1);
        check_eq("ct0_d_gnt", d_gnt, 0);
        check_eq("ct0_stall", c_stall, 0);
        set_in(1'b1, 1'b1, 1'b1, 16'h0002, 16'hC0C0, 1'b1, 1'b1, 16'h0100, 16'hD0D0, 1'b0);
        check_eq("ct1_d_gnt", d_gnt, 1);
        check_eq("ct1_c_gnt", c_gnt, 0);
        check_eq("ct1_stall", c_stall, 1);
        check_eq("ct1_mem_en", mem_en, 1);
        check_eq("ct1_mem_we", mem_we, 1);
        check_eq("ct1_mem_addr", mem_addr, 16'h0002);
        check_eq("ct1_mem_wdata", mem_wdata, 16'hC0C0);
        set_in(1'b1, 1'b1, 1'b1, 16'h0002, 16'hC0C0, 1'b1, 1'b1, 16'h0100, 16'hD0D0, 1'b0);
        check_eq("ct2_c_gnt", c_gnt, 1);
        check_eq("ct2_mem_addr", mem_addr, 16'h0100);
        check_eq("ct2_mem_wdata", mem_wdata, 16'hD0D0);
        set_in(1'b1, 1'b1, 1'b1, 16'h0002, 16'hC0C0, 1'b1, 1'b1, 16'h0100, 16'hD0D0, 1'b0);
        check_eq("ct3_d_gnt", d_gnt, 1);
        check_eq("ct3_mem_addr", mem_addr, 16'h0002);
        idle();
        check_eq("ct4_mem_addr", mem_addr, 16'h0100);
        check_eq("ct4_mem_en", mem_en, 1);
        idle();
        check_eq("ct5_mem_en", mem_en, 0);

        // Core-only read of 0x0010
        set_in(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check_eq("cr0_c_gnt", c_gnt, 1);
        check_eq("cr0_stall", c_stall, 1);
        idle();
        check_eq("cr1_mem_en", mem_en, 1);
        check_eq("cr1_mem_we", mem_we, 0);
        check_eq("cr1_mem_addr", mem_addr, 16'h0010);
        check_eq("cr1_stall", c_stall, 1);
        check_eq("cr1_c_rvalid", c_rvalid, 0);
        idle();
        check_eq("cr2_c_rvalid", c_rvalid, 1);
        check_eq("cr2_c_rdata", c_rdata, 16'hBEEF);
        check_eq("cr2_d_rvalid", d_rvalid, 0);
        check_eq("cr2_stall", c_stall, 0);
        idle();
        check_eq("cr3_c_rvalid", c_rvalid, 0);
        check_eq("cr3_c_rdata_hold", c_rdata, 16'hBEEF);

        // Read routing: D reads 0x0020, then C reads 0x0030 one cycle later
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
        check_eq("rt0_d_gnt", d_gnt, 1);
        set_in(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check_eq("rt1_c_gnt", c_gnt, 1);
        check_eq("rt1_mem_addr", mem_addr, 16'h0020);
        idle();
        check_eq("rt2_d_rvalid", d_rvalid, 1);
        check_eq("rt2_d_rdata", d_rdata, 16'h1111);
        check_eq("rt2_c_rvalid", c_rvalid, 0);
        check_eq("rt2_stall", c_stall, 1);
        check_eq("rt2_mem_addr", mem_addr, 16'h0030);
        idle();
        check_eq("rt3_c_rvalid", c_rvalid, 1);
        check_eq("rt3_c_rdata", c_rdata, 16'h2222);
        check_eq("rt3_d_rvalid", d_rvalid, 0);
        check_eq("rt3_d_rdata_hold", d_rdata, 16'h1111);

        // Lock with drain: core read in flight when d_lock rises
        set_in(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check_eq("lk0_c_gnt", c_gnt, 1);
        set_in(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        check_eq("lk1_c_gnt_inflight", c_gnt, 0);
        check_eq("lk1_stall", c_stall, 1);
        set_in(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h5A5A, 1'b1);
        check_eq("lk2_drain_d_gnt", d_gnt, 0);
        check_eq("lk2_drain_c_gnt", c_gnt, 0);
        check_eq("lk2_c_rvalid", c_rvalid, 1);
        check_eq("lk2_c_rdata", c_rdata, 16'hBEEF);
        check_eq("lk2_stall", c_stall, 1);
        set_in(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h5A5A, 1'b1);
        check_eq("lk3_dlock_d_gnt", d_gnt, 1);
        check_eq("lk3_dlock_c_gnt", c_gnt, 0);
        check_eq("lk3_stall", c_stall, 1);
        set_in(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check_eq("lk4_c_gnt", c_gnt, 0);
        check_eq("lk4_mem_addr", mem_addr, 16'h0040);
        check_eq("lk4_mem_wdata", mem_wdata, 16'h5A5A);
        set_in(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h0, 1'b0);
        check_eq("lk5_c_gnt", c_gnt, 1);
        check_eq("lk5_d_gnt", d_gnt, 0);

        // Second lock with no D grant inside: exit must park the pointer on C
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        check_eq("lk6_stall", c_stall, 1);
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b1);
        check_eq("lk7_drain_d_gnt", d_gnt, 0);
        check_eq("lk7_c_rvalid", c_rvalid, 1);
        set_in(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check_eq("lk8_c_gnt", c_gnt, 0);
        check_eq("lk8_stall", c_stall, 1);
        set_in(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b1, 1'b1, 16'h0044, 16'h0, 1'b0);
        check_eq("lk9_ptr_c_gnt", c_gnt, 1);
        check_eq("lk9_ptr_d_gnt", d_gnt, 0);
        idle();
        check_eq("lk10_mem_addr", mem_addr, 16'h0030);
        idle();
        check_eq("lk11_c_rvalid", c_rvalid, 1);
        check_eq("lk11_c_rdata", c_rdata, 16'h2222);

        // Reset the cycle after a core read grant: the read is discarded
        idle();
        set_in(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check_eq("rr0_c_gnt", c_gnt, 1);
        set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check_eq("rr1_mem_en", mem_en, 0);
        check_eq("rr1_stall", c_stall, 0);
        check_eq("rr1_c_rvalid", c_rvalid, 0);
        idle();
        check_eq("rr2_c_rvalid", c_rvalid, 0);
        check_eq("rr2_c_rdata", c_rdata, 0);
        idle();
        check_eq("rr3_c_rvalid", c_rvalid, 0);
        check_eq("rr3_mem_en", mem_en, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single 16-bit data memory between two requesters: the core load/store path (port C) and the external debug/program-loader port (port D).
- Accepts at most one transaction per cycle and registers the winning command onto the memory bus.
- Routes read data back to the requester that issued the read, using an in-flight owner tag pipeline.
- Generates the core stall used to freeze the PC register while a core access is pending.

Parameters:
ADDR_W, 16, byte address width of both requester ports and the memory port
DATA_W, 16, data word width
RD_LAT, 1, memory read latency in cycles from mem_en (read) to valid mem_rdata; legal 1..4

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset; 0 = reset asserted
c_req  in  1  core requests an access this cycle
c_we  in  1  core access is a write
c_addr  in  ADDR_W  core address
c_wdata  in  DATA_W  core write data
c_gnt  out  1  core command accepted this cycle (combinational)
c_rvalid  out  1  core read data valid
c_rdata  out  DATA_W  core read data
c_stall  out  1  core must hold PC and command
d_req  in  1  debug port requests an access
d_we  in  1  debug access is a write
d_addr  in  ADDR_W  debug address
d_wdata  in  DATA_W  debug write data
d_lock  in  1  debug port requests exclusive ownership
d_gnt  out  1  debug command accepted this cycle (combinational)
d_rvalid  out  1  debug read data valid
d_rdata  out  DATA_W  debug read data
mem_en  out  1  registered memory command strobe
mem_we  out  1  registered write enable
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after a read command

Behaviour:
- Reset (reset=0, asynchronous):
  - mem_en, mem_we, c_rvalid, d_rvalid, c_stall = 0.
  - mem_addr, mem_wdata, c_rdata, d_rdata = 0.
  - Round-robin pointer = C; FSM = ARB; tag pipeline cleared.
- FSM states:
  - ARB: normal round-robin arbitration.
  - DLOCK: port D exclusive.
  - DRAIN: waiting for in-flight reads to complete before entering DLOCK.
- FSM transitions:
  - ARB -> DRAIN when d_lock=1.
  - DRAIN -> DLOCK when no read is in flight; stay in DRAIN otherwise.
  - DLOCK -> ARB when d_lock=0. On this exit, the pointer is set to C.
  - In DRAIN, no grants are issued.
  - In DLOCK, d_gnt = d_req and c_gnt = 0.
- Arbitration in ARB:
  - If only one port requests, that port wins.
  - If both request, the pointer's port wins.
  - The pointer moves to the other port after every grant.
  - Worst-case wait for either port is therefore 1 cycle.
- Grant and command timing:
  - A grant in cycle N registers {mem_en=1, mem_we, mem_addr, mem_wdata} at the edge ending N, so the command is visible in N+1.
  - mem_en = 0 in any cycle following a no-grant cycle.
- Read return:
  - A read granted in N returns mem_rdata to the owner in cycle N+1+RD_LAT, with {x_rvalid, x_rdata} registered.
  - Owner tag and valid flag travel in a (RD_LAT+1)-deep shift register.
  - x_rdata holds its last value when x_rvalid=0.
- Writes: complete at the grant; no response is generated.
- Stall (combinational): c_stall = (c_req & ~c_gnt) | core read outstanding with c_rvalid not yet asserted.
  - The core issues at most one read outstanding; a core req while its own read is in flight is not granted.
- Back-to-back and simultaneous events:
  - A new grant in the same cycle as an rvalid is allowed; the pipeline is fully pipelined.
  - d_lock deasserted during DRAIN returns the FSM to ARB next cycle.
- Reset mid-operation: all in-flight reads are discarded; no rvalid is produced after reset releases.
- Address/data are not modified; byte-address alignment is the requester's responsibility.

Decomposition:
- Package dmem_pkg:
  - ADDR_W and DATA_W defaults.
  - Requester ID constants REQ_C=0 and REQ_D=1.
  - FSM state encoding ARB/DRAIN/DLOCK as a 2-bit typedef.
- Sub-module rr_arb2: two-input round-robin grant plus pointer register with a force-to-C input; the rest stays in dmem_arbiter.

Test Plan:
- Reset: hold reset=0 for 3 cycles with both reqs=1 -> all outputs 0, no grants.
- Core-only read: c_req=1, c_we=0, c_addr=0x0010; mem_rdata=0xBEEF after RD_LAT=1 -> c_gnt in N, mem_en/mem_addr=0x0010 in N+1, c_rvalid=1 with c_rdata=0xBEEF in N+2, c_stall=1 in N and N+1.
- Contention: both req continuously, writes c_addr=0x0002 / d_addr=0x0100 -> grants alternate C,D,C,D; mem_addr sequence 0x0002,0x0100,0x0002.
- Read return routing: D read 0x0020 granted N, C read 0x0030 granted N+1, memory returns 0x1111 then 0x2222 -> d_rvalid/0x1111 at N+2, c_rvalid/0x2222 at N+3, never crossed.
- Lock with drain: core read in flight, assert d_lock -> DRAIN one cycle, then DLOCK; c_gnt=0 and c_stall=1 while locked; d_lock=0 -> next contended grant goes to C.
- Reset mid-read: reset=0 the cycle after a core read grant -> no c_rvalid ever appears for it; mem_en=0 immediately.
